// File: rtl/barcode_pkg.sv
// Shared definitions for the barcode serializer: widths, parameter defaults and FSM states.
package barcode_pkg;

  localparam int unsigned PATTERN_WIDTH         = 49;
  localparam int unsigned BIT_IDX_W             = 6;
  localparam int unsigned MODULE_CYCLES_DEFAULT = 4;
  localparam int unsigned QUIET_BITS_DEFAULT    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_QUIET,
    ST_DATA,
    ST_TRAIL_QUIET,
    ST_DONE
  } state_e;

endpackage

// File: rtl/barcode_serializer_if.sv
// Signal bundle for driving and observing one barcode serializer.
interface barcode_serializer_if;
  import barcode_pkg::*;

  logic                     Start;
  logic [PATTERN_WIDTH-1:0] PatternIn;
  logic                     BarOut;
  logic                     Busy;
  logic                     Done;
  logic                     Error;
  logic [BIT_IDX_W-1:0]     BitIndex;

  modport master (
    output Start, PatternIn,
    input  BarOut, Busy, Done, Error, BitIndex
  );

  modport slave (
    input  Start, PatternIn,
    output BarOut, Busy, Done, Error, BitIndex
  );

endinterface

// File: rtl/bar_tick_gen.sv
// Module-rate tick: one-cycle pulse every MODULE_CYCLES cycles, restartable by clear.
module bar_tick_gen #(
  parameter int unsigned MODULE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned    CW   = (MODULE_CYCLES > 1) ? $clog2(MODULE_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(MODULE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/barcode_serializer.sv
// Serializes a latched 49-module barcode pattern MSB first, framed by leading and trailing quiet zones.
module barcode_serializer
  import barcode_pkg::*;
#(
  parameter int unsigned MODULE_CYCLES = MODULE_CYCLES_DEFAULT,
  parameter int unsigned QUIET_BITS    = QUIET_BITS_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [PATTERN_WIDTH-1:0] PatternIn,
  output logic                     BarOut,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Error,
  output logic [BIT_IDX_W-1:0]     BitIndex
);

  localparam int unsigned           QW         = (QUIET_BITS > 1) ? $clog2(QUIET_BITS) : 1;
  localparam logic [QW-1:0]         QUIET_LAST = QW'(QUIET_BITS - 1);
  localparam logic [BIT_IDX_W-1:0]  MSB_IDX    = BIT_IDX_W'(PATTERN_WIDTH - 1);

  state_e                   state_q, state_d;
  logic [PATTERN_WIDTH-1:0] pattern_q, pattern_d;
  logic [BIT_IDX_W-1:0]     bit_q, bit_d;
  logic [QW-1:0]            quiet_q, quiet_d;
  logic                     bar_out_q, bar_out_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [BIT_IDX_W-1:0]     bit_index_q, bit_index_d;

  logic tick;
  logic can_start;
  logic start_ok;
  logic start_bad;

  // DONE accepts a new Start exactly like IDLE so transmissions can run back to back.
  assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok  = can_start && Start && (PatternIn != '0);
  assign start_bad = can_start && Start && (PatternIn == '0);

  bar_tick_gen #(
    .MODULE_CYCLES(MODULE_CYCLES)
  ) u_tick (
    .clk  (Clk),
    .rst  (Reset),
    .clear(start_ok),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    bit_d     = bit_q;
    quiet_d   = quiet_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_ok) begin
          state_d   = ST_LEAD_QUIET;
          pattern_d = PatternIn;
          quiet_d   = '0;
          bit_d     = MSB_IDX;
        end
      end
      ST_LEAD_QUIET: begin
        if (tick) begin
          if (quiet_q == QUIET_LAST) begin
            state_d = ST_DATA;
            quiet_d = '0;
          end else begin
            quiet_d = quiet_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == '0) begin
            state_d = ST_TRAIL_QUIET;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      ST_TRAIL_QUIET: begin
        if (tick) begin
          if (quiet_q == QUIET_LAST) begin
            state_d = ST_DONE;
            quiet_d = '0;
          end else begin
            quiet_d = quiet_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from next-state values so they leave the block straight from flops.
    busy_d      = (state_d == ST_LEAD_QUIET) || (state_d == ST_DATA) || (state_d == ST_TRAIL_QUIET);
    done_d      = (state_d == ST_DONE);
    error_d     = start_bad;
    bar_out_d   = (state_d == ST_DATA) ? pattern_d[bit_d] : 1'b0;
    bit_index_d = (state_d == ST_DATA) ? bit_d : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      bit_q       <= '0;
      quiet_q     <= '0;
      bar_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      bit_index_q <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      bit_q       <= bit_d;
      quiet_q     <= quiet_d;
      bar_out_q   <= bar_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      bit_index_q <= bit_index_d;
    end
  end

  assign BarOut   = bar_out_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign BitIndex = bit_index_q;

endmodule

// File: tb/tb_barcode_serializer.sv
// Scoreboard bench: three serializer configurations, expected patterns queued at Start, checked at Done.
module tb_barcode_serializer;

  localparam int NDUT = 3;

  function automatic int unsigned mc_of(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned qb_of(input int g);
    case (g)
      0:       return 10;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a [NDUT];
  logic [48:0] pat_a   [NDUT];
  logic [NDUT-1:0] bar_w, busy_w, done_w, err_w;
  logic [5:0]  idx_w   [NDUT];

  logic [48:0] exp_q   [NDUT][$];
  logic [6:0]  trace_q [NDUT][$];
  int          done_cnt  [NDUT];
  int          err_cnt   [NDUT];
  bit          prev_done [NDUT];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    barcode_serializer_if bif ();
    assign bif.Start     = start_a[g];
    assign bif.PatternIn = pat_a[g];
    assign bar_w[g]      = bif.BarOut;
    assign busy_w[g]     = bif.Busy;
    assign done_w[g]     = bif.Done;
    assign err_w[g]      = bif.Error;
    assign idx_w[g]      = bif.BitIndex;

    barcode_serializer #(
      .MODULE_CYCLES(mc_of(g)),
      .QUIET_BITS   (qb_of(g))
    ) u_dut (
      .Clk      (clk),
      .Reset    (rst),
      .Start    (bif.Start),
      .PatternIn(bif.PatternIn),
      .BarOut   (bif.BarOut),
      .Busy     (bif.Busy),
      .Done     (bif.Done),
      .Error    (bif.Error),
      .BitIndex (bif.BitIndex)
    );
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the transmission is Q*M zeros, 49 modules of M cycles each (bit 48 first), Q*M zeros.
  task automatic check_txn(input int g);
    int unsigned m, q, len, sz, mod, b, t;
    int mism_bar, mism_idx;
    logic [48:0] pat, rec;
    logic exp_bar;
    logic [5:0] exp_idx;
    m = mc_of(g);
    q = qb_of(g);
    len = (2 * q + 49) * m;
    done_cnt[g]++;
    check(!busy_w[g] && !bar_w[g], $sformatf("dut%0d done_outputs", g), 64'({busy_w[g], bar_w[g]}), 64'd0);
    check(!prev_done[g], $sformatf("dut%0d done_width", g), 64'(prev_done[g]), 64'd0);
    if (exp_q[g].size() == 0) begin
      check(1'b0, $sformatf("dut%0d unexpected_done", g), 64'(done_cnt[g]), 64'd0);
      trace_q[g].delete();
      return;
    end
    pat = exp_q[g].pop_front();
    sz = trace_q[g].size();
    check(sz == len, $sformatf("dut%0d busy_len", g), 64'(sz), 64'(len));
    mism_bar = 0;
    mism_idx = 0;
    for (int unsigned i = 0; i < sz; i++) begin
      mod = i / m;
      if (mod >= q && mod < q + 49) begin
        b = 48 - (mod - q);
        exp_bar = pat[b];
        exp_idx = 6'(b);
      end else begin
        exp_bar = 1'b0;
        exp_idx = '0;
      end
      if (trace_q[g][i][6] != exp_bar) mism_bar++;
      if (trace_q[g][i][5:0] != exp_idx) mism_idx++;
    end
    check(mism_bar == 0, $sformatf("dut%0d bar_stream", g), 64'(mism_bar), 64'd0);
    check(mism_idx == 0, $sformatf("dut%0d bit_index", g), 64'(mism_idx), 64'd0);
    rec = '0;
    for (int unsigned k = 0; k < 49; k++) begin
      t = (q + k) * m + m / 2;
      if (t < sz) rec[48-k] = trace_q[g][t][6];
    end
    check(rec == pat, $sformatf("dut%0d reconstruct", g), 64'(rec), 64'(pat));
    trace_q[g].delete();
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (rst) begin
        trace_q[g].delete();
        prev_done[g] = 1'b0;
      end else begin
        if (busy_w[g]) trace_q[g].push_back({bar_w[g], idx_w[g]});
        if (done_w[g]) begin
          check_txn(g);
        end else if (!busy_w[g] && trace_q[g].size() != 0) begin
          check(1'b0, $sformatf("dut%0d busy_dropped_without_done", g), 64'(trace_q[g].size()), 64'd0);
          trace_q[g].delete();
        end
        if (err_w[g]) err_cnt[g]++;
        prev_done[g] = done_w[g];
      end
    end
  end

  task automatic issue(input int g, input logic [48:0] p);
    @(posedge clk);
    #1;
    start_a[g] = 1'b1;
    pat_a[g]   = p;
    if (p != '0) exp_q[g].push_back(p);
    @(posedge clk);
    #1;
    start_a[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int base, n, budget;
    base = done_cnt[g];
    budget = int'((2 * qb_of(g) + 49) * mc_of(g)) + 20;
    n = 0;
    while (done_cnt[g] == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(done_cnt[g] != base, $sformatf("dut%0d done_timeout", g), 64'(n), 64'(budget));
  endtask

  function automatic logic [48:0] rand_pat();
    logic [48:0] p;
    p = {$urandom, $urandom};
    if (p == '0) p = 49'd1;
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lows, lows_not_done;
    int base;
    logic [48:0] a;
    for (int g = 0; g < NDUT; g++) begin
      start_a[g] = 1'b0;
      pat_a[g]   = '0;
      done_cnt[g] = 0;
      err_cnt[g]  = 0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      check({bar_w[g], busy_w[g], done_w[g], err_w[g], idx_w[g]} == '0,
            $sformatf("dut%0d reset_outputs", g),
            64'({bar_w[g], busy_w[g], done_w[g], err_w[g], idx_w[g]}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-bar-at-each-end pattern on the default configuration
    issue(0, 49'h1_0000_0000_0001);
    wait_done(0);

    // Zero pattern is rejected with a one-cycle Error
    issue(0, 49'd0);
    @(negedge clk);
    check(err_w[0] && !busy_w[0] && !bar_w[0], "error_pulse", 64'({err_w[0], busy_w[0], bar_w[0]}), 64'h4);
    @(negedge clk);
    check(!err_w[0] && !busy_w[0] && !bar_w[0], "error_one_cycle", 64'({err_w[0], busy_w[0], bar_w[0]}), 64'h0);

    // Start and PatternIn disturbed during DATA must not affect the stream
    a = rand_pat();
    issue(0, a);
    repeat (60) @(posedge clk);
    #1;
    start_a[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pat_a[0] = rand_pat();
      @(posedge clk);
      #1;
    end
    start_a[0] = 1'b0;
    wait_done(0);

    // Reset at cycle 100 aborts without Done
    issue(0, {49{1'b1}});
    repeat (99) @(posedge clk);
    @(negedge clk);
    check(busy_w[0] && bar_w[0] && idx_w[0] == 6'd34, "pre_reset_state",
          64'({busy_w[0], bar_w[0], idx_w[0]}), 64'({1'b1, 1'b1, 6'd34}));
    #1;
    rst = 1'b1;
    void'(exp_q[0].pop_back());
    @(posedge clk);
    @(negedge clk);
    check(!busy_w[0] && !bar_w[0] && idx_w[0] == '0 && !done_w[0], "reset_abort",
          64'({busy_w[0], bar_w[0], idx_w[0], done_w[0]}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = done_cnt[0];
    repeat (300) @(negedge clk);
    check(done_cnt[0] == base, "no_done_after_abort", 64'(done_cnt[0] - base), 64'd0);

    // Start held through DONE: two back-to-back transmissions, Busy low only in DONE
    a = rand_pat();
    @(posedge clk);
    #1;
    start_a[1] = 1'b1;
    pat_a[1]   = a;
    exp_q[1].push_back(a);
    exp_q[1].push_back(a);
    @(posedge clk);
    lows = 0;
    lows_not_done = 0;
    for (int i = 1; i <= 104; i++) begin
      @(negedge clk);
      if (!busy_w[1]) lows++;
      if (!busy_w[1] && !done_w[1]) lows_not_done++;
      if (i == 103) start_a[1] = 1'b0;
    end
    check(lows == 2, "b2b_busy_low_cycles", 64'(lows), 64'd2);
    check(lows_not_done == 0, "b2b_idle_gap", 64'(lows_not_done), 64'd0);
    @(negedge clk);

    // Random patterns across module widths 4, 1, 3
    for (int g = 0; g < NDUT; g++) begin
      for (int n = 0; n < ((g == 0) ? 3 : 6); n++) begin
        issue(g, rand_pat());
        wait_done(g);
      end
    end

    repeat (5) @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      check(exp_q[g].size() == 0, $sformatf("dut%0d pending_expected", g), 64'(exp_q[g].size()), 64'd0);
    check(err_cnt[0] == 1 && err_cnt[1] == 0 && err_cnt[2] == 0, "error_pulse_count",
          64'({err_cnt[0][7:0], err_cnt[1][7:0], err_cnt[2][7:0]}), 64'h010000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barcode_serializer.md
BARCODE_SERIALIZER -- requirements
Module: barcode_serializer

Interface
REQ-001 Parameter MODULE_CYCLES, default 4, SHALL set the clock cycles each bar module (one bit) is held on BarOut; legal range >= 1.
REQ-002 Parameter QUIET_BITS, default 10, SHALL set the module count of each quiet zone (leading and trailing); legal range >= 1.
REQ-003 Clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to serialize PatternIn; sampled on every rising edge.
REQ-006 PatternIn  input  49  barcode module pattern from the pattern generator; 1 = bar, 0 = space.
REQ-007 BarOut  output  1  serial bar stream to the printer/LED driver.
REQ-008 Busy  output  1  high while a transmission is in progress.
REQ-009 Done  output  1  one-cycle pulse marking completion of a transmission.
REQ-010 Error  output  1  one-cycle pulse marking a rejected Start.
REQ-011 BitIndex  output  6  index of the PatternIn bit currently on BarOut during DATA; 0 in all other states.

Function
REQ-012 The block SHALL implement states IDLE, LEAD_QUIET, DATA, TRAIL_QUIET, DONE.
REQ-013 In IDLE, with Start=1 and PatternIn != 0, the block SHALL latch PatternIn into an internal 49-bit register and enter LEAD_QUIET on the next edge.
REQ-014 In IDLE, with Start=1 and PatternIn == 0, the block SHALL pulse Error for exactly one cycle and remain in IDLE.
REQ-015 Start SHALL be ignored in LEAD_QUIET, DATA and TRAIL_QUIET; changes on PatternIn after latching SHALL NOT affect the output.
REQ-016 LEAD_QUIET SHALL last QUIET_BITS*MODULE_CYCLES cycles with BarOut=0, then enter DATA.
REQ-017 DATA SHALL output the latched bits MSB first (bit 48 down to bit 0), each held for exactly MODULE_CYCLES cycles.
REQ-018 In DATA, BarOut SHALL equal latched[BitIndex].
REQ-019 DATA SHALL last 49*MODULE_CYCLES cycles, then enter TRAIL_QUIET.
REQ-020 TRAIL_QUIET SHALL last QUIET_BITS*MODULE_CYCLES cycles with BarOut=0, then enter DONE.
REQ-021 DONE SHALL last one cycle with Done=1, Busy=0 and BarOut=0, then return to IDLE.
REQ-022 A Start that is valid per REQ-013 and sampled during DONE SHALL be accepted exactly as in IDLE, giving back-to-back transmissions with no IDLE cycle.
REQ-023 Busy SHALL be 1 exactly in LEAD_QUIET, DATA and TRAIL_QUIET, i.e. for (2*QUIET_BITS+49)*MODULE_CYCLES cycles; with defaults this is 276 cycles.
REQ-024 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-025 The module-cycle counter SHALL wrap from MODULE_CYCLES-1 to 0; the bit counter SHALL NOT wrap below 0. Leaving DATA at bit 0 is the terminal condition.

Reset
REQ-026 Reset=1 at a rising edge SHALL force IDLE and set BarOut=0, Busy=0, Done=0, Error=0, BitIndex=0, all counters to 0 and the pattern register to 0.
REQ-027 Reset asserted mid-transmission SHALL abort immediately, with no Done pulse; Start SHALL be ignored in any cycle where Reset=1.

Structure
REQ-028 A shared package barcode_pkg SHALL hold the state enumeration, the constant PATTERN_WIDTH=49 and the default values of MODULE_CYCLES and QUIET_BITS.
REQ-029 One sub-module, bar_tick_gen, SHALL generate a one-cycle tick every MODULE_CYCLES cycles; it is cleared by Reset and on each accepted Start.
REQ-030 The FSM and the bit/quiet counters SHALL live in barcode_serializer.

Verification
REQ-031 Defaults; PatternIn=49'h1_0000_0000_0001; one Start pulse -> Busy high for 276 cycles; first BarOut=1 at cycle 41 after Start, held 4 cycles; last BarOut=1 held at cycles 233–236; Done pulses at cycle 277.
REQ-032 Start with PatternIn=0 -> Error=1 for one cycle; Busy stays 0; BarOut stays 0.
REQ-033 Start re-pulsed and PatternIn changed during DATA -> output bitstream identical to the first latched pattern; no restart.
REQ-034 Reset asserted at cycle 100 of a transmission -> next cycle Busy=0, BarOut=0, BitIndex=0; no Done pulse.
REQ-035 Start held high through DONE with MODULE_CYCLES=1, QUIET_BITS=1 -> second transmission begins with no IDLE cycle; Busy low only in the DONE cycle.
REQ-036 Random nonzero patterns, MODULE_CYCLES in {1,3,4} -> scoreboard reconstructs PatternIn exactly from BarOut sampled at module centres.
